// File: rtl/qspi_xip_sequencer.sv
// qspi_xip_sequencer
//
// Read-only AXI4-Lite execute-in-place front end. Each CPU word read that falls in the
// XIP window is turned into a fixed register sequence on the QSPI master's AXI4-Lite
// control port: write flash address, write trigger, poll status until not busy, read
// data. Reads outside the window return SLVERR with no master traffic. One CPU read is
// in flight at a time.
//
// Optional build macro XIP_CACHE_EN: adds a one-entry word cache so a repeated read of
// the same word is answered without master traffic.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axi_ar* / s_axi_r*   CPU-side AXI4-Lite read channel (slave)
//   m_axi_aw* / m_axi_w*   QSPI register writes (master); wstrb fixed to 4'hF
//   m_axi_b*               write response; bresp ignored, bready fixed high
//   m_axi_ar* / m_axi_r*   QSPI register reads (master); rresp ignored, rready fixed high
module qspi_xip_sequencer #(
    parameter logic [31:0] XIP_BASE      = 32'h2000_0000,
    parameter logic [31:0] CTRL_BASE     = 32'h1000_0000,
    parameter int unsigned TIMEOUT_POLLS = 256,
    parameter int unsigned POLL_GAP      = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam int unsigned PollW = $clog2(TIMEOUT_POLLS + 1);
    localparam int unsigned GapW  = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);

    localparam logic [31:0] RegTrig   = CTRL_BASE + 32'h00;
    localparam logic [31:0] RegAddr   = CTRL_BASE + 32'h04;
    localparam logic [31:0] RegData   = CTRL_BASE + 32'h08;
    localparam logic [31:0] RegStatus = CTRL_BASE + 32'h28;

    typedef enum logic [3:0] {
        StIdle, StWrAddr, StWaitB1, StWrTrig, StWaitB2, StGap,
        StPollAr, StPollR, StDataAr, StDataR, StResp
    } state_e;

    state_e             state_q, state_d;
    logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [31:0]        awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [PollW-1:0]   poll_cnt_q, poll_cnt_d, poll_inc;
    logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
    logic               in_window, aw_done, w_done;
    logic               cache_hit;
    logic [31:0]        cache_data;
    logic               unused_addr_bits;

    // Byte offset within the word is irrelevant for word reads.
    assign unused_addr_bits = ^s_axi_araddr[1:0];

    assign in_window = (s_axi_araddr[31:24] == XIP_BASE[31:24]);
    assign poll_inc  = poll_cnt_q + 1'b1;
    // A channel counts as done once its valid has been accepted (or is accepted now).
    assign aw_done   = !awvalid_q || m_axi_awready;
    assign w_done    = !wvalid_q || m_axi_wready;

`ifdef XIP_CACHE_EN
    logic        cache_valid_q;
    logic [21:0] cache_tag_q, req_tag_q;
    logic [31:0] cache_data_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            req_tag_q     <= '0;
            cache_data_q  <= '0;
        end else begin
            if (state_q == StIdle && s_axi_arvalid) begin
                req_tag_q <= s_axi_araddr[23:2];
            end
            if (state_q == StDataR && m_axi_rvalid) begin
                cache_valid_q <= 1'b1;
                cache_tag_q   <= req_tag_q;
                cache_data_q  <= m_axi_rdata;
            end
        end
    end

    assign cache_hit  = cache_valid_q && (cache_tag_q == s_axi_araddr[23:2]);
    assign cache_data = cache_data_q;
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (s_axi_arvalid) begin
                    if (!in_window) begin
                        state_d  = StResp;
                        rvalid_d = 1'b1;
                        rresp_d  = 2'b10;
                        rdata_d  = '0;
                    end else if (cache_hit) begin
                        state_d  = StResp;
                        rvalid_d = 1'b1;
                        rresp_d  = 2'b00;
                        rdata_d  = cache_data;
                    end else begin
                        state_d    = StWrAddr;
                        awvalid_d  = 1'b1;
                        wvalid_d   = 1'b1;
                        awaddr_d   = RegAddr;
                        wdata_d    = {8'h00, s_axi_araddr[23:2], 2'b00};
                        poll_cnt_d = '0;
                    end
                end
            end
            StWrAddr, StWrTrig: begin
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d = (state_q == StWrAddr) ? StWaitB1 : StWaitB2;
                end
            end
            StWaitB1: begin
                if (m_axi_bvalid) begin
                    state_d   = StWrTrig;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = RegTrig;
                    wdata_d   = 32'h1;
                end
            end
            StWaitB2: begin
                if (m_axi_bvalid) begin
                    gap_cnt_d = '0;
                    if (POLL_GAP == 0) begin
                        state_d   = StPollAr;
                        arvalid_d = 1'b1;
                        araddr_d  = RegStatus;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapW'(POLL_GAP - 1)) begin
                    state_d   = StPollAr;
                    arvalid_d = 1'b1;
                    araddr_d  = RegStatus;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            StPollAr, StDataAr: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = (state_q == StPollAr) ? StPollR : StDataR;
                end
            end
            StPollR: begin
                if (m_axi_rvalid) begin
                    poll_cnt_d = poll_inc;
                    if (!m_axi_rdata[0]) begin
                        state_d   = StDataAr;
                        arvalid_d = 1'b1;
                        araddr_d  = RegData;
                    end else if (poll_inc == PollW'(TIMEOUT_POLLS)) begin
                        state_d  = StResp;
                        rvalid_d = 1'b1;
                        rresp_d  = 2'b10;
                        rdata_d  = '0;
                    end else begin
                        state_d   = StPollAr;
                        arvalid_d = 1'b1;
                        araddr_d  = RegStatus;
                    end
                end
            end
            StDataR: begin
                if (m_axi_rvalid) begin
                    state_d  = StResp;
                    rvalid_d = 1'b1;
                    rresp_d  = 2'b00;
                    rdata_d  = m_axi_rdata;
                end
            end
            StResp: begin
                if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign s_axi_arready = (state_q == StIdle);
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = 1'b1;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = 1'b1;

endmodule

// File: tb/tb_qspi_xip_sequencer.sv
// Scoreboard bench for qspi_xip_sequencer: a QSPI register stub with random ready
// backpressure, a CPU-side driver, and a negedge monitor that pops expectations.
module tb_qspi_xip_sequencer;

    localparam int unsigned TO  = 4;
    localparam int unsigned GAP = 2;
    localparam logic [31:0] CB  = 32'h1000_0000;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    always #5 aclk = ~aclk;

    qspi_xip_sequencer #(
        .XIP_BASE     (32'h2000_0000),
        .CTRL_BASE    (CB),
        .TIMEOUT_POLLS(TO),
        .POLL_GAP     (GAP)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } mtxn_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        fast;
    } stxn_t;

    mtxn_t exp_m[$];
    stxn_t exp_s[$];
    int    checks = 0;
    int    fails  = 0;

`ifdef XIP_CACHE_EN
    bit          mc_valid = 1'b0;
    logic [21:0] mc_tag = '0;
`endif

    // Flash contents: little-endian EF BE AD DE at 0x104, a hash elsewhere.
    function automatic logic [31:0] flash_word(input logic [31:0] fa);
        if (fa == 32'h0000_0104) return 32'hDEAD_BEEF;
        return (fa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Handshake events seen by the monitor, consumed by the stub after the next edge.
    bit          st_aw, st_w, st_ar, st_r, st_b;
    logic [31:0] st_aw_addr, st_w_data, st_ar_addr;
    int unsigned busy_left = 0;
    int unsigned hold_low = 0;

    // QSPI master register stub.
    initial begin : stub
        bit          got_aw, got_w;
        logic [31:0] aw_l, w_l, reg_addr, rnd;
        got_aw = 0; got_w = 0; aw_l = '0; w_l = '0; reg_addr = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
                got_aw = 0; got_w = 0; reg_addr = '0;
                st_aw = 0; st_w = 0; st_ar = 0; st_r = 0; st_b = 0;
            end else begin
                if (st_aw) begin got_aw = 1; aw_l = st_aw_addr; st_aw = 0; end
                if (st_w) begin got_w = 1; w_l = st_w_data; st_w = 0; end
                if (st_b) begin m_axi_bvalid = 0; st_b = 0; end
                if (got_aw && got_w && !m_axi_bvalid) begin
                    if (aw_l == CB + 32'h04) reg_addr = w_l;
                    m_axi_bvalid = 1;
                    got_aw = 0; got_w = 0;
                end
                if (st_r) begin m_axi_rvalid = 0; st_r = 0; end
                if (st_ar) begin
                    st_ar = 0;
                    m_axi_rvalid = 1;
                    if (st_ar_addr == CB + 32'h28) begin
                        rnd = $urandom;
                        m_axi_rdata = {rnd[31:1], busy_left > 0};
                        if (busy_left > 0) busy_left--;
                    end else if (st_ar_addr == CB + 32'h08) begin
                        m_axi_rdata = flash_word(reg_addr);
                    end else begin
                        m_axi_rdata = 32'hBAD0_BAD0;
                    end
                end
                m_axi_awready = 1'($urandom_range(0, 1));
                m_axi_wready  = 1'($urandom_range(0, 1));
                m_axi_arready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : rready_drv
        forever begin
            @(posedge aclk);
            #1;
            if (hold_low > 0) begin
                s_axi_rready = 0;
                hold_low--;
            end else begin
                s_axi_rready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor / scoreboard.
    int          cyc = 0, s_ar_cyc = 0, m_r_cyc = 0, b_cyc = 0;
    bit          aw_cap, w_cap, trig_written, gap_pending, in_resp, hold_bad, stray_rep;
    logic [31:0] cap_aw, cap_w, hold_d;
    logic [1:0]  hold_r;
    mtxn_t       mon_m;
    stxn_t       mon_s;

    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) begin
            aw_cap = 0; w_cap = 0; in_resp = 0; trig_written = 0; gap_pending = 0;
        end else begin
            if ((m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) && exp_m.size() == 0 &&
                !stray_rep) begin
                stray_rep = 1;
                checks++;
                fails++;
                $display("FAIL stray_master: valids aw=%0b w=%0b ar=%0b, required none",
                         m_axi_awvalid, m_axi_wvalid, m_axi_arvalid);
            end
            if (gap_pending && m_axi_arvalid) begin
                gap_pending = 0;
                check32("poll_gap_cycle", 32'(cyc), 32'(b_cyc + GAP + 1));
            end
            if (m_axi_bvalid) begin
                st_b = 1;
                if (trig_written) begin
                    trig_written = 0;
                    gap_pending = 1;
                    b_cyc = cyc;
                end
            end
            if (m_axi_awvalid && m_axi_awready) begin
                aw_cap = 1; cap_aw = m_axi_awaddr; st_aw = 1; st_aw_addr = m_axi_awaddr;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_cap = 1; cap_w = m_axi_wdata; st_w = 1; st_w_data = m_axi_wdata;
            end
            if (aw_cap && w_cap) begin
                aw_cap = 0; w_cap = 0;
                if (exp_m.size() == 0) begin
                    check32("extra_write_addr", cap_aw, 32'hFFFF_FFFF);
                end else begin
                    mon_m = exp_m.pop_front();
                    check32("wr_addr", cap_aw, mon_m.is_wr ? mon_m.addr : 32'hFFFF_FFFF);
                    check32("wr_data", cap_w, mon_m.data);
                    if (mon_m.addr == CB) trig_written = 1;
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                st_ar = 1; st_ar_addr = m_axi_araddr;
                if (exp_m.size() == 0) begin
                    check32("extra_read_addr", m_axi_araddr, 32'hFFFF_FFFF);
                end else begin
                    mon_m = exp_m.pop_front();
                    check32("rd_addr", m_axi_araddr, mon_m.is_wr ? 32'hFFFF_FFFF : mon_m.addr);
                end
            end
            if (m_axi_rvalid) begin
                st_r = 1;
                m_r_cyc = cyc;
            end
            if (s_axi_arvalid && s_axi_arready) s_ar_cyc = cyc;
            if (s_axi_rvalid) begin
                if (!in_resp) begin
                    in_resp = 1; hold_bad = 0; hold_d = s_axi_rdata; hold_r = s_axi_rresp;
                    if (exp_s.size() == 0) begin
                        check32("unexpected_resp", s_axi_rdata, 32'hFFFF_FFFF);
                    end else begin
                        mon_s = exp_s[0];
                        check32("resp_latency", 32'(cyc),
                                mon_s.fast ? 32'(s_ar_cyc + 1) : 32'(m_r_cyc + 1));
                    end
                end else if (s_axi_rdata !== hold_d || s_axi_rresp !== hold_r) begin
                    hold_bad = 1;
                end
                if (s_axi_arready) hold_bad = 1;
                if (s_axi_rready) begin
                    in_resp = 0;
                    if (exp_s.size() != 0) begin
                        mon_s = exp_s.pop_front();
                        check32("rdata", s_axi_rdata, mon_s.data);
                        check32("rresp", {30'b0, s_axi_rresp}, {30'b0, mon_s.resp});
                        check32("resp_hold_stable", {31'b0, hold_bad}, 32'h0);
                    end
                end
            end
        end
    end

    // Reference model: push expected master sequence and CPU response, then drive AR.
    task automatic issue(input logic [31:0] addr, input int unsigned busy);
        logic [31:0] fa;
        int unsigned polls;
        bit          hit;
        bit          done;
        fa  = {8'h00, addr[23:2], 2'b00};
        hit = 0;
`ifdef XIP_CACHE_EN
        hit = mc_valid && (mc_tag == addr[23:2]);
`endif
        if (addr[31:24] != 8'h20) begin
            exp_s.push_back(stxn_t'{32'h0, 2'b10, 1'b1});
        end else if (hit) begin
            exp_s.push_back(stxn_t'{flash_word(fa), 2'b00, 1'b1});
        end else begin
            exp_m.push_back(mtxn_t'{1'b1, CB + 32'h04, fa});
            exp_m.push_back(mtxn_t'{1'b1, CB, 32'h1});
            polls = (busy < TO) ? busy + 1 : TO;
            repeat (polls) exp_m.push_back(mtxn_t'{1'b0, CB + 32'h28, 32'h0});
            if (busy < TO) begin
                exp_m.push_back(mtxn_t'{1'b0, CB + 32'h08, 32'h0});
                exp_s.push_back(stxn_t'{flash_word(fa), 2'b00, 1'b0});
`ifdef XIP_CACHE_EN
                mc_valid = 1;
                mc_tag   = addr[23:2];
`endif
            end else begin
                exp_s.push_back(stxn_t'{32'h0, 2'b10, 1'b0});
            end
        end
        busy_left = busy;
        @(posedge aclk);
        #1;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1;
        done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (s_axi_arready) begin done = 1; break; end
        end
        if (!done) check32("ar_handshake_timeout", 32'h0, 32'h1);
        @(posedge aclk);
        #1;
        s_axi_arvalid = 0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge aclk);
            #2;
            if (exp_s.size() == 0 && exp_m.size() == 0 && !s_axi_rvalid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL txn_timeout: %0d responses and %0d master txns still pending, required 0",
                     exp_s.size(), exp_m.size());
            exp_s.delete();
            exp_m.delete();
        end
        stray_rep = 0;
    endtask

    task automatic reset_checks();
        check32("rst_s_rvalid", {31'b0, s_axi_rvalid}, 32'h0);
        check32("rst_s_rdata", s_axi_rdata, 32'h0);
        check32("rst_s_rresp", {30'b0, s_axi_rresp}, 32'h0);
        check32("rst_s_arready", {31'b0, s_axi_arready}, 32'h1);
        check32("rst_m_valids", {29'b0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'h0);
        check32("rst_m_awaddr", m_axi_awaddr, 32'h0);
        check32("rst_m_wdata", m_axi_wdata, 32'h0);
        check32("rst_m_araddr", m_axi_araddr, 32'h0);
        check32("const_wstrb_bready_rready", {26'b0, m_axi_wstrb, m_axi_bready, m_axi_rready},
                32'h3F);
    endtask

    initial begin : main
        logic [31:0] a;
        logic [7:0]  top;
        bit          found;
        #1 aresetn = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        reset_checks();
        @(posedge aclk);
        #1 aresetn = 1;

        issue(32'h2000_0106, 2);            // DEADBEEF fetch with two busy polls
        wait_done();
        issue(32'h3000_0000, 0);            // outside window
        wait_done();
        issue(32'h2000_0200, 100);          // status never clears
        wait_done();
        hold_low = 14;                      // CPU stalls rready in RESP
        issue(32'h2100_0040, 0);
        wait_done();

        // Reset while waiting on a status read.
        issue(32'h2000_0300, 3);
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (m_axi_arvalid && m_axi_arready && m_axi_araddr == CB + 32'h28) begin
                found = 1;
                break;
            end
        end
        if (!found) check32("poll_not_reached", 32'h0, 32'h1);
        @(posedge aclk);
        #1;
        aresetn = 0;
        exp_m.delete();
        exp_s.delete();
`ifdef XIP_CACHE_EN
        mc_valid = 0;
`endif
        @(negedge aclk);
        reset_checks();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1;
        stray_rep = 0;
        issue(32'h2000_0104, 1);
        wait_done();

        // Repeat, then neighbouring word.
        issue(32'h2000_0104, 0);
        wait_done();
        issue(32'h2000_0108, 0);
        wait_done();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                top = 8'($urandom_range(0, 255));
                if (top == 8'h20) top = 8'h21;
                a = $urandom;
                a[31:24] = top;
            end else begin
                a = 32'h2000_0100 + 32'($urandom_range(0, 23));
            end
            issue(a, $urandom_range(0, 5));
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
